// File: rtl/uart_rx_parity_if.sv
// ---------------------------------------------------------------------------
// uart_rx_parity_if
// Bundles the serial line, the parity configuration and the received-byte
// status of the UART receiver.
//   rx            serial line into the receiver (idles high)
//   parity_type   01 = odd, 10 = even, 00/11 = no parity bit in the frame
//   data_out      last received byte
//   data_valid    one-cycle pulse when a frame completes
//   parity_error  parity status of the last frame
//   frame_error   stop bit sampled low on the last frame
//   busy          receiver is inside a frame
// Modports: master = line/configuration side, slave = receiver side.
// ---------------------------------------------------------------------------
interface uart_rx_parity_if;
    logic       rx;
    logic [1:0] parity_type;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       frame_error;
    logic       busy;

    modport master (
        output rx,
        output parity_type,
        input  data_out,
        input  data_valid,
        input  parity_error,
        input  frame_error,
        input  busy
    );

    modport slave (
        input  rx,
        input  parity_type,
        output data_out,
        output data_valid,
        output parity_error,
        output frame_error,
        output busy
    );
endinterface

// File: rtl/uart_rx_parity.sv
// ---------------------------------------------------------------------------
// uart_rx_parity
// UART receiver: synchronizes the asynchronous rx line, deframes one start
// bit, 8 data bits (LSB first), an optional odd/even parity bit and one stop
// bit, then presents the byte together with parity and framing status.
// Ports:
//   clk      system clock, rising edge
//   reset_n  synchronous active-low reset
//   bus      uart_rx_parity_if.slave (rx, parity_type in; data_out,
//            data_valid, parity_error, frame_error, busy out)
// Parameter:
//   CLKS_PER_BIT  clk cycles per bit period (>= 4)
// ---------------------------------------------------------------------------
module uart_rx_parity #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              clk,
    input  logic              reset_n,
    uart_rx_parity_if.slave   bus
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'((CLKS_PER_BIT / 2) - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO      = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

    localparam logic [1:0] PTYPE_ODD  = 2'b01;
    localparam logic [1:0] PTYPE_EVEN = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity check of a received byte against its parity bit; frames
    // without a parity bit never report an error.
    function automatic logic f_parity_error(
        input logic [1:0] ptype,
        input logic       pbit,
        input logic [7:0] data
    );
        logic err;
        case (ptype)
            PTYPE_ODD:  err = (pbit != ~^data);
            PTYPE_EVEN: err = (pbit != ^data);
            default:    err = 1'b0;
        endcase
        return err;
    endfunction

    state_t           r_state;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic             r_rx_d;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [1:0]       r_ptype;
    logic [7:0]       r_shreg;
    logic             r_pbit;
    logic [7:0]       r_data_out;
    logic             r_data_valid;
    logic             r_parity_error;
    logic             r_frame_error;
    logic             r_busy;
    logic             w_has_parity;

    assign w_has_parity = (r_ptype == PTYPE_ODD) || (r_ptype == PTYPE_EVEN);

    // Two-flop synchronizer for rx plus one delay stage for edge detection;
    // all reset to the idle (high) line level so no false start follows reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_d    <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx;
            r_rx_s    <= r_rx_meta;
            r_rx_d    <= r_rx_s;
        end
    end

    // Receive FSM with bit timing, deframing and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_clk_cnt      <= CNT_ZERO;
            r_bit_idx      <= 3'd0;
            r_ptype        <= 2'b00;
            r_shreg        <= 8'h00;
            r_pbit         <= 1'b0;
            r_data_out     <= 8'h00;
            r_data_valid   <= 1'b0;
            r_parity_error <= 1'b0;
            r_frame_error  <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_clk_cnt <= CNT_ZERO;
                    r_bit_idx <= 3'd0;
                    // Falling edge needs a high level first, so a held-low
                    // line (break) cannot retrigger a frame.
                    if (r_rx_d && !r_rx_s) begin
                        r_state <= ST_START;
                        r_ptype <= bus.parity_type;
                        r_busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (r_clk_cnt == CNT_HALF_LAST) begin
                        r_clk_cnt <= CNT_ZERO;
                        if (!r_rx_s) begin
                            r_state <= ST_DATA;
                        end else begin
                            // Line went back high mid start bit: glitch.
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (r_clk_cnt == CNT_BIT_LAST) begin
                        r_clk_cnt          <= CNT_ZERO;
                        r_shreg[r_bit_idx] <= r_rx_s;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= 3'd0;
                            r_state   <= w_has_parity ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end
                ST_PARITY: begin
                    if (r_clk_cnt == CNT_BIT_LAST) begin
                        r_clk_cnt <= CNT_ZERO;
                        r_pbit    <= r_rx_s;
                        r_state   <= ST_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (r_clk_cnt == CNT_BIT_LAST) begin
                        r_clk_cnt      <= CNT_ZERO;
                        r_data_out     <= r_shreg;
                        r_frame_error  <= ~r_rx_s;
                        r_parity_error <= f_parity_error(r_ptype, r_pbit, r_shreg);
                        r_data_valid   <= 1'b1;
                        r_busy         <= 1'b0;
                        r_state        <= ST_IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_clk_cnt <= CNT_ZERO;
                    r_bit_idx <= 3'd0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out     = r_data_out;
    assign bus.data_valid   = r_data_valid;
    assign bus.parity_error = r_parity_error;
    assign bus.frame_error  = r_frame_error;
    assign bus.busy         = r_busy;

endmodule

// File: tb/tb_uart_rx_parity.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_parity
// Drives UART frames on rx and keeps a frame-level expectation for each one:
// when busy must be high, the cycle data_valid must pulse and the byte and
// flags it must carry. Every cycle after reset, one compare process checks
// all outputs against that expectation. Directed frames pin the expectation
// with literal values, followed by randomized frames.
// Cycle n is the interval after the n-th rising clock edge. rx is driven low
// in cycle t; rx_s is then low from cycle t+2, so busy rises in cycle t+3 and
// data_valid is high in cycle t+3 + C/2 + 9C (+C with a parity bit).
// ---------------------------------------------------------------------------
module tb_uart_rx_parity;

    localparam int C = 16;

    logic clk = 1'b0;
    logic reset_n;

    uart_rx_parity_if bus ();

    uart_rx_parity #(.CLKS_PER_BIT(C)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         bs;      // first cycle busy is high
        int         be;      // first cycle busy is low again (data_valid cycle)
        bit         has_dv;
        logic [7:0] d;
        bit         pe;
        bit         fe;
    } exp_t;

    exp_t       q[$];
    int         cyc      = 0;
    int         n_chk    = 0;
    int         n_err    = 0;
    int         dv_count = 0;
    int         cap_cyc  = 0;
    int         last_t   = 0;
    logic [7:0] m_data   = 8'h00;
    logic       m_pe     = 1'b0;
    logic       m_fe     = 1'b0;
    logic [7:0] cap_data = 8'h00;
    logic [7:0] cap_prev = 8'h00;
    logic       cap_pe   = 1'b0;
    logic       cap_fe   = 1'b0;
    bit         chk_en   = 1'b0;
    logic       e_dv;
    logic       e_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle counter; a synchronous reset clears the held outputs.
    always @(posedge clk) begin
        cyc++;
        if (reset_n === 1'b0) begin
            m_data = 8'h00;
            m_pe   = 1'b0;
            m_fe   = 1'b0;
        end
    end

    // Per-cycle comparison of every output against the frame expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            e_dv   = 1'b0;
            e_busy = 1'b0;
            if (q.size() > 0 && cyc > q[0].be) begin
                chk("stale_expectation", cyc, q[0].be);
                q.delete(0);
            end
            if (q.size() > 0) begin
                if (cyc >= q[0].bs && cyc < q[0].be) e_busy = 1'b1;
                if (cyc == q[0].be) begin
                    if (q[0].has_dv) begin
                        e_dv   = 1'b1;
                        m_data = q[0].d;
                        m_pe   = q[0].pe;
                        m_fe   = q[0].fe;
                    end
                    q.delete(0);
                end
            end
            chk("data_valid",   bus.data_valid,   e_dv);
            chk("busy",         bus.busy,         e_busy);
            chk("data_out",     bus.data_out,     m_data);
            chk("parity_error", bus.parity_error, m_pe);
            chk("frame_error",  bus.frame_error,  m_fe);
            if (bus.data_valid === 1'b1) begin
                dv_count++;
                cap_prev = cap_data;
                cap_data = bus.data_out;
                cap_pe   = bus.parity_error;
                cap_fe   = bus.frame_error;
                cap_cyc  = cyc;
            end
        end
    end

    // One frame; abort_bit >= 0 asserts reset in the middle of that data bit.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic pb,
                              input logic sb, input int stop_len, input int gap,
                              input int abort_bit);
        exp_t e;
        bit   has_par;
        int   ones;
        int   t;
        has_par = (pt == 2'b01) || (pt == 2'b10);
        ones    = $countones(d) + int'(pb);
        @(negedge clk);
        t        = cyc;
        last_t   = t;
        e.bs     = t + 3;
        e.has_dv = (abort_bit < 0);
        e.d      = d;
        e.pe     = (pt == 2'b01) ? (ones % 2 == 0) : (pt == 2'b10) ? (ones % 2 == 1) : 1'b0;
        e.fe     = ~sb;
        e.be     = (abort_bit < 0) ? (t + 3 + C/2 + 9*C + (has_par ? C : 0))
                                   : (t + (abort_bit + 1)*C + C/2 + 1);
        q.push_back(e);
        bus.parity_type = pt;
        bus.rx          = 1'b0;
        repeat (C) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            bus.rx = d[k];
            if (k == abort_bit) begin
                repeat (C/2) @(negedge clk);
                reset_n = 1'b0;
                bus.rx  = 1'b1;
                repeat (2) @(negedge clk);
                reset_n = 1'b1;
                repeat (4) @(negedge clk);
                return;
            end
            // Configuration changes mid-frame must not affect this frame.
            if (k == 4) bus.parity_type = 2'($urandom_range(0, 3));
            repeat (C) @(negedge clk);
        end
        if (has_par) begin
            bus.rx = pb;
            repeat (C) @(negedge clk);
        end
        bus.rx = sb;
        repeat (stop_len) @(negedge clk);
        bus.rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_glitch();
        exp_t e;
        @(negedge clk);
        e.bs     = cyc + 3;
        e.be     = cyc + 3 + C/2;
        e.has_dv = 1'b0;
        e.d      = 8'h00;
        e.pe     = 1'b0;
        e.fe     = 1'b0;
        q.push_back(e);
        bus.rx = 1'b0;
        repeat (3) @(negedge clk);
        bus.rx = 1'b1;
        repeat (C + 4) @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && q.size() > 0; i++) @(negedge clk);
        chk("idle_timeout_pending", q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_one(input string tag, input int n0, input logic [7:0] d,
                              input logic pe, input logic fe);
        chk({tag, "_count"}, dv_count, n0 + 1);
        chk({tag, "_data"},  cap_data, d);
        chk({tag, "_perr"},  cap_pe,   pe);
        chk({tag, "_ferr"},  cap_fe,   fe);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int n0;
        int n_rand;
        reset_n         = 1'b0;
        bus.rx          = 1'b1;
        bus.parity_type = 2'b00;
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_data_out",   bus.data_out,     8'h00);
        chk("rst_data_valid", bus.data_valid,   1'b0);
        chk("rst_busy",       bus.busy,         1'b0);
        chk("rst_perr",       bus.parity_error, 1'b0);
        chk("rst_ferr",       bus.frame_error,  1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // No parity, 0xA5: data_valid 3 + 8 + 144 cycles after rx falls.
        n0 = dv_count;
        send_frame(8'hA5, 2'b00, 1'b0, 1'b1, C, 10, -1);
        wait_idle();
        expect_one("np_a5", n0, 8'hA5, 1'b0, 1'b0);
        chk("np_a5_latency", cap_cyc - last_t, 155);

        // Odd parity, 0x03 (two ones): parity bit 1 is correct.
        n0 = dv_count;
        send_frame(8'h03, 2'b01, 1'b1, 1'b1, C, 10, -1);
        wait_idle();
        expect_one("odd_ok", n0, 8'h03, 1'b0, 1'b0);
        chk("odd_latency", cap_cyc - last_t, 171);
        n0 = dv_count;
        send_frame(8'h03, 2'b01, 1'b0, 1'b1, C, 10, -1);
        wait_idle();
        expect_one("odd_bad", n0, 8'h03, 1'b1, 1'b0);

        // Even parity, 0x07 (three ones): parity bit 1 is correct.
        n0 = dv_count;
        send_frame(8'h07, 2'b10, 1'b1, 1'b1, C, 10, -1);
        wait_idle();
        expect_one("even_ok", n0, 8'h07, 1'b0, 1'b0);
        n0 = dv_count;
        send_frame(8'h07, 2'b10, 1'b0, 1'b1, C, 10, -1);
        wait_idle();
        expect_one("even_bad", n0, 8'h07, 1'b1, 1'b0);

        // Stop bit low.
        n0 = dv_count;
        send_frame(8'h55, 2'b00, 1'b0, 1'b0, C, 10, -1);
        wait_idle();
        expect_one("frame_err", n0, 8'h55, 1'b0, 1'b1);

        // Short low glitch: false start, no byte.
        n0 = dv_count;
        send_glitch();
        wait_idle();
        chk("glitch_no_dv", dv_count, n0);
        chk("glitch_busy",  bus.busy, 1'b0);

        // Reset during data bit 4, then a clean frame.
        n0 = dv_count;
        send_frame(8'h99, 2'b00, 1'b0, 1'b1, C, 10, 4);
        chk("abort_no_dv",    dv_count,         n0);
        chk("abort_data_out", bus.data_out,     8'h00);
        chk("abort_ferr",     bus.frame_error,  1'b0);
        wait_idle();
        n0 = dv_count;
        send_frame(8'h3C, 2'b00, 1'b0, 1'b1, C, 10, -1);
        wait_idle();
        expect_one("after_rst", n0, 8'h3C, 1'b0, 1'b0);

        // Back-to-back with a stop bit of C/2 + 1 cycles before the next start.
        n0 = dv_count;
        send_frame(8'h12, 2'b00, 1'b0, 1'b1, C/2, 0, -1);
        send_frame(8'h34, 2'b00, 1'b0, 1'b1, C, 10, -1);
        wait_idle();
        chk("b2b_count", dv_count, n0 + 2);
        chk("b2b_first", cap_prev, 8'h12);
        chk("b2b_second", cap_data, 8'h34);
        chk("b2b_perr",  cap_pe,   1'b0);
        chk("b2b_ferr",  cap_fe,   1'b0);

        // Randomized frames.
        n0     = dv_count;
        n_rand = 30;
        for (int i = 0; i < n_rand; i++) begin
            logic sb;
            sb = ($urandom_range(0, 7) != 0);
            if (sb)
                send_frame(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                           1'b1, $urandom_range(C/2, C + 2), $urandom_range(0, 5), -1);
            else
                send_frame(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                           1'b0, C, $urandom_range(2, 6), -1);
        end
        wait_idle();
        chk("rand_count", dv_count, n0 + n_rand);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
